// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  // Responder FSM encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // One enable bit per byte of a 32-bit word.
  localparam int unsigned BE_W = 4;

  // Number of word-index bits needed to address DEPTH words.
  function automatic int unsigned idx_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage with byte-enabled synchronous write and
// combinational read. Contents are deliberately not reset.
module dmem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DATA_W/8-1:0]   i_be,
  output logic [DATA_W-1:0]     o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write only the enabled byte lanes of the addressed word.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (i_be[i]) begin
          r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory interface: one outstanding request,
// fixed response latency, response held until the initiator takes it.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IDX_W    = idx_width(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_e            r_state, w_state_d;
  logic [3:0]        r_cnt, w_cnt_d;
  logic              r_req_ready, w_req_ready_d;
  logic              r_resp_valid, w_resp_valid_d;
  logic [DATA_W-1:0] r_hold, w_hold_d;
  logic              r_err, w_err_d;

  logic              w_accept;
  logic              w_misaligned;
  logic              w_out_of_range;
  logic              w_bad;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_mem_rdata;

  assign w_idx          = req_addr[IDX_W+1:2];
  assign w_misaligned   = |req_addr[1:0];
  assign w_out_of_range = |(req_addr >> (IDX_W + 2));
  assign w_bad          = w_misaligned | w_out_of_range;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .i_clk   (Clk),
    .i_we    (w_accept & req_we & ~w_bad),
    .i_idx   (w_idx),
    .i_wdata (req_wdata),
    .i_be    (req_be),
    .o_rdata (w_mem_rdata)
  );

  // State, counter and registered handshake/response outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_hold       <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_req_ready  <= w_req_ready_d;
      r_resp_valid <= w_resp_valid_d;
      r_hold       <= w_hold_d;
      r_err        <= w_err_d;
    end
  end

  // Next-state logic; request fields are sampled only on acceptance.
  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = r_cnt;
    w_req_ready_d  = r_req_ready;
    w_resp_valid_d = r_resp_valid;
    w_hold_d       = r_hold;
    w_err_d        = r_err;
    w_accept       = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_req_ready_d = 1'b1;
        // req_ready is still low on the first cycle after reset release.
        if (req_valid && r_req_ready) begin
          w_accept      = 1'b1;
          w_state_d     = WAIT;
          w_cnt_d       = CNT_INIT;
          w_req_ready_d = 1'b0;
          w_err_d       = w_bad;
          w_hold_d      = (w_bad || req_we) ? '0 : w_mem_rdata;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_d      = RESP;
          w_resp_valid_d = 1'b1;
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          w_state_d      = IDLE;
          w_resp_valid_d = 1'b0;
          w_hold_d       = '0;
          w_err_d        = 1'b0;
          w_req_ready_d  = 1'b1;
        end
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  // Hold register is loaded at acceptance; expose it only while responding.
  assign resp_rdata = r_resp_valid ? r_hold : '0;
  assign resp_err   = r_resp_valid & r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a response scoreboard.
// Instance 0 uses LATENCY=2, instance 1 LATENCY=1, instance 2 LATENCY=15.
module tb_data_mem_responder;

  localparam int unsigned LAT [3] = '{2, 1, 15};

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid  [3];
  logic        req_we     [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [3:0]  req_be     [3];
  logic        resp_ready [3];
  wire         req_ready  [3];
  wire         resp_valid [3];
  wire         resp_err   [3];
  wire  [31:0] resp_rdata [3];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(
      .DATA_W  (32),
      .ADDR_W  (32),
      .DEPTH   (256),
      .LATENCY (LAT[g])
    ) u_dut (
      .Clk        (clk),
      .Reset      (rst_n),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_be     (req_be[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request until accepted; optionally record its expected response.
  task automatic do_req(input int k, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input logic push, output int acc);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_be[k]    = be;
    req_valid[k] = 1'b1;
    while (req_ready[k] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("req_accepted", 32'(n < 40), 32'd1);
    @(posedge clk);
    #1;
    acc          = cyc;
    req_valid[k] = 1'b0;
    if (push) begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      sb.push_back(e);
    end
  endtask

  // Wait for the response, compare against the scoreboard, optionally stall.
  task automatic get_resp(input int k, input int acc, input int hold);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (resp_valid[k] !== 1'b1 && n < 40);
    chk("resp_seen", 32'(n < 40), 32'd1);
    chk("latency", 32'(cyc - acc), LAT[k]);
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
    end else begin
      e.rdata = 'x;
      e.err   = 1'bx;
    end
    chk("rdata", resp_rdata[k], e.rdata);
    chk("err", 32'(resp_err[k]), 32'(e.err));
    for (int i = 0; i < hold; i++) begin
      // Requests offered while a response is pending must be ignored.
      req_we[k]    = 1'b1;
      req_addr[k]  = 32'h0;
      req_wdata[k] = 32'hFFFF_FFFF;
      req_be[k]    = 4'hF;
      req_valid[k] = 1'b1;
      @(negedge clk);
      chk("bp_valid", 32'(resp_valid[k]), 32'd1);
      chk("bp_rdata", resp_rdata[k], e.rdata);
      chk("bp_req_ready", 32'(req_ready[k]), 32'd0);
    end
    req_valid[k]  = 1'b0;
    resp_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_valid", 32'(resp_valid[k]), 32'd0);
    chk("hs_rdata", resp_rdata[k], 32'd0);
    chk("hs_err", 32'(resp_err[k]), 32'd0);
    chk("hs_req_ready", 32'(req_ready[k]), 32'd1);
  endtask

  task automatic xact(input int k, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic [31:0] exp_rd, input logic exp_err,
                      input int hold, output int acc);
    do_req(k, we, addr, wdata, be, exp_rd, exp_err, 1'b1, acc);
    get_resp(k, acc, hold);
  endtask

  initial begin
    int acc;
    int accs [3];
    int cnt;

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid[k]  = 1'b0;
      req_we[k]     = 1'b0;
      req_addr[k]   = 32'h0;
      req_wdata[k]  = 32'h0;
      req_be[k]     = 4'h0;
      resp_ready[k] = 1'b1;
    end

    // Reset values, then req_ready rises one edge after release.
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_req_ready", 32'(req_ready[k]), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid[k]), 32'd0);
      chk("rst_resp_rdata", resp_rdata[k], 32'd0);
      chk("rst_resp_err", 32'(resp_err[k]), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("rel_req_ready_low", 32'(req_ready[0]), 32'd0);
    @(posedge clk);
    #1;
    chk("rel_req_ready_high", 32'(req_ready[0]), 32'd1);

    // Store then load.
    xact(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 0, acc);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0, acc);

    // Byte enables, including an all-disabled store.
    xact(0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, 0, acc);
    xact(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDE22_BE44, 1'b0, 0, acc);
    xact(0, 1'b1, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0, 0, acc);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, 0, acc);

    // Errors: misaligned load, out-of-range store that would alias word 0.
    xact(0, 1'b1, 32'h0, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0, 0, acc);
    xact(0, 1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1, 0, acc);
    xact(0, 1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 0, acc);
    xact(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 0, acc);

    // Response backpressure with ignored request pulses.
    resp_ready[0] = 1'b0;
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, 5, acc);
    xact(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 0, acc);

    // Latency extremes and back-to-back spacing.
    for (int k = 1; k < 3; k++) begin
      xact(k, 1'b1, 32'h40, 32'h1234_5670 + 32'(k), 4'hF, 32'h0, 1'b0, 0, acc);
      for (int i = 0; i < 3; i++) begin
        xact(k, 1'b0, 32'h40, 32'h0, 4'h0, 32'h1234_5670 + 32'(k), 1'b0, 0, accs[i]);
      end
      chk("spacing_1", 32'(accs[1] - accs[0]), LAT[k] + 2);
      chk("spacing_2", 32'(accs[2] - accs[1]), LAT[k] + 2);
    end

    // Reset during WAIT drops the load; the earlier store survives.
    xact(0, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 0, acc);
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, acc);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_resp_valid", 32'(resp_valid[0]), 32'd0);
    chk("midrst_req_ready", 32'(req_ready[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid[0] === 1'b1) cnt++;
    end
    chk("midrst_no_resp", 32'(cnt), 32'd0);
    xact(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 0, acc);

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
